// File: rtl/arbitro_memoria.sv
// Two-port arbiter for the Polilock password RAM: round-robin ownership,
// address/data mux, read-valid strobes and timeout revocation of long grants.
module arbitro_memoria #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 4,
    parameter int TIMEOUT    = 200,
    parameter int TW         = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  en0,
    input  logic                  en1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic                  estouro,
    output logic [1:0]            db_estado
);

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        DONO0  = 2'd1,
        DONO1  = 2'd2,
        LIBERA = 2'd3
    } estado_t;

    localparam logic [TW-1:0] LIMITE = TW'(TIMEOUT - 1);

    estado_t         r_estado;
    logic            r_ultimo;
    logic            r_bloq0;
    logic            r_bloq1;
    logic [TW-1:0]   r_cnt;
    logic            r_rvalid0;
    logic            r_rvalid1;
    logic            r_estouro;

    estado_t         w_prox;
    logic            w_eleg0;
    logic            w_eleg1;
    logic            w_limite;
    logic            w_tout0;
    logic            w_tout1;

    assign w_eleg0  = req0 & ~r_bloq0;
    assign w_eleg1  = req1 & ~r_bloq1;
    assign w_limite = (r_cnt == LIMITE);

    // A release seen on the limit cycle wins over the timeout: no estouro, no block.
    always_comb begin
        w_prox  = r_estado;
        w_tout0 = 1'b0;
        w_tout1 = 1'b0;
        case (r_estado)
            OCIOSO, LIBERA: begin
                if (w_eleg0 && w_eleg1)
                    w_prox = r_ultimo ? DONO0 : DONO1;
                else if (w_eleg0)
                    w_prox = DONO0;
                else if (w_eleg1)
                    w_prox = DONO1;
                else
                    w_prox = OCIOSO;
            end
            DONO0: begin
                if (!req0) begin
                    w_prox = LIBERA;
                end else if (w_limite) begin
                    w_prox  = LIBERA;
                    w_tout0 = 1'b1;
                end
            end
            DONO1: begin
                if (!req1) begin
                    w_prox = LIBERA;
                end else if (w_limite) begin
                    w_prox  = LIBERA;
                    w_tout1 = 1'b1;
                end
            end
            default: w_prox = OCIOSO;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado  <= OCIOSO;
            r_ultimo  <= 1'b1;
            r_bloq0   <= 1'b0;
            r_bloq1   <= 1'b0;
            r_cnt     <= '0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_estouro <= 1'b0;
        end else begin
            r_estado <= w_prox;
            if (w_prox == DONO0)
                r_ultimo <= 1'b0;
            else if (w_prox == DONO1)
                r_ultimo <= 1'b1;

            if (!req0)
                r_bloq0 <= 1'b0;
            else if (w_tout0)
                r_bloq0 <= 1'b1;
            if (!req1)
                r_bloq1 <= 1'b0;
            else if (w_tout1)
                r_bloq1 <= 1'b1;

            // Every grant passes through LIBERA/OCIOSO first, so clearing there restarts the count.
            if (!(gnt0 || gnt1))
                r_cnt <= '0;
            else if (!w_limite)
                r_cnt <= r_cnt + 1'b1;

            r_rvalid0 <= gnt0 & en0 & ~we0;
            r_rvalid1 <= gnt1 & en1 & ~we1;
            r_estouro <= w_tout0 | w_tout1;
        end
    end

    assign gnt0 = (r_estado == DONO0);
    assign gnt1 = (r_estado == DONO1);

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (gnt0) begin
            mem_addr  = addr0;
            mem_wdata = wdata0;
            mem_we    = en0 & we0;
        end else if (gnt1) begin
            mem_addr  = addr1;
            mem_wdata = wdata1;
            mem_we    = en1 & we1;
        end
    end

    assign rdata     = mem_rdata;
    assign rvalid0   = r_rvalid0;
    assign rvalid1   = r_rvalid1;
    assign estouro   = r_estouro;
    assign db_estado = r_estado;

endmodule

// File: tb/tb_arbitro_memoria.sv
// Self-checking bench for arbitro_memoria: per-cycle vector tables with a read
// scoreboard, a behavioural RAM, and a hand-written asynchronous reset sequence.
module tb_arbitro_memoria;

    typedef struct {
        logic       r0, r1, e0, w0, e1, w1;
        logic [3:0] a0, d0, a1, d1;
        logic [1:0] st;
        logic       est;
    } vec_t;

    typedef struct {
        logic       port;
        logic [3:0] data;
    } leitura_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       req0, req1, en0, en1, we0, we1;
    logic [3:0] addr0, addr1, wdata0, wdata1;
    logic [3:0] mem_rdata;
    logic       gnt0, gnt1, mem_we, rvalid0, rvalid1, estouro;
    logic [3:0] mem_addr, mem_wdata, rdata;
    logic [1:0] db_estado;

    logic [3:0] ram [16];
    logic [3:0] modelMem [16];
    vec_t       vecs[$];
    leitura_t   sb[$];
    int         checks   = 0;
    int         failures = 0;

    arbitro_memoria #(.ADDR_WIDTH(4), .DATA_WIDTH(4), .TIMEOUT(8), .TW(8)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .en0(en0), .en1(en1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .mem_rdata(mem_rdata),
        .gnt0(gnt0), .gnt1(gnt1), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .rdata(rdata), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .estouro(estouro), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // Synchronous RAM with one-cycle read latency, the arbiter's real load.
    always @(posedge clock) begin
        if (mem_we)
            ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    function automatic vec_t mk(input logic r0, input logic r1, input logic [1:0] st,
                                input logic est,
                                input logic e0 = 1'b0, input logic w0 = 1'b0,
                                input logic [3:0] a0 = 4'd0, input logic [3:0] d0 = 4'd0,
                                input logic e1 = 1'b0, input logic w1 = 1'b0,
                                input logic [3:0] a1 = 4'd0, input logic [3:0] d1 = 4'd0);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.st = st; v.est = est;
        v.e0 = e0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.e1 = e1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] actual,
                               input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        req0 = v.r0; req1 = v.r1;
        en0 = v.e0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
        en1 = v.e1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
    endtask

    task automatic resetDut();
        reset = 1'b1;
        applyStimulus(mk(0, 0, 2'd0, 0));
        repeat (2) @(negedge clock);
        reset = 1'b0;
        sb.delete();
    endtask

    // One vector per cycle: inputs set after the falling edge, outputs compared 1 ns later.
    task automatic runTable(input string tag);
        leitura_t   item;
        logic       g0, g1, expWe;
        logic [3:0] expAddr, expWdata;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            applyStimulus(vecs[i]);
            #1;
            g0       = (vecs[i].st == 2'd1);
            g1       = (vecs[i].st == 2'd2);
            expWe    = g0 ? (vecs[i].e0 & vecs[i].w0) : g1 ? (vecs[i].e1 & vecs[i].w1) : 1'b0;
            expAddr  = g0 ? vecs[i].a0 : g1 ? vecs[i].a1 : 4'd0;
            expWdata = g0 ? vecs[i].d0 : g1 ? vecs[i].d1 : 4'd0;
            checkOutput($sformatf("%s[%0d].db_estado", tag, i), 8'(db_estado), 8'(vecs[i].st));
            checkOutput($sformatf("%s[%0d].gnt0", tag, i), 8'(gnt0), 8'(g0));
            checkOutput($sformatf("%s[%0d].gnt1", tag, i), 8'(gnt1), 8'(g1));
            checkOutput($sformatf("%s[%0d].estouro", tag, i), 8'(estouro), 8'(vecs[i].est));
            checkOutput($sformatf("%s[%0d].mem_we", tag, i), 8'(mem_we), 8'(expWe));
            checkOutput($sformatf("%s[%0d].mem_addr", tag, i), 8'(mem_addr), 8'(expAddr));
            checkOutput($sformatf("%s[%0d].mem_wdata", tag, i), 8'(mem_wdata), 8'(expWdata));
            if (sb.size() > 0) begin
                item = sb.pop_front();
                checkOutput($sformatf("%s[%0d].rvalid0", tag, i), 8'(rvalid0), 8'(item.port == 1'b0));
                checkOutput($sformatf("%s[%0d].rvalid1", tag, i), 8'(rvalid1), 8'(item.port == 1'b1));
                checkOutput($sformatf("%s[%0d].rdata", tag, i), 8'(rdata), 8'(item.data));
            end else begin
                checkOutput($sformatf("%s[%0d].rvalid0", tag, i), 8'(rvalid0), 8'd0);
                checkOutput($sformatf("%s[%0d].rvalid1", tag, i), 8'(rvalid1), 8'd0);
            end
            if (g0 && vecs[i].e0 && vecs[i].w0) modelMem[vecs[i].a0] = vecs[i].d0;
            if (g1 && vecs[i].e1 && vecs[i].w1) modelMem[vecs[i].a1] = vecs[i].d1;
            if (g0 && vecs[i].e0 && !vecs[i].w0) sb.push_back('{1'b0, modelMem[vecs[i].a0]});
            if (g1 && vecs[i].e1 && !vecs[i].w1) sb.push_back('{1'b1, modelMem[vecs[i].a1]});
        end
        checkOutput({tag, ".drain"}, 8'(sb.size()), 8'd0);
        vecs.delete();
    endtask

    initial begin
        for (int k = 0; k < 16; k++) begin
            ram[k]      = 4'd0;
            modelMem[k] = 4'd0;
        end
        reset = 1'b1;
        applyStimulus(mk(0, 0, 2'd0, 0));
        @(negedge clock);
        #1;
        checkOutput("reset.db_estado", 8'(db_estado), 8'd0);
        checkOutput("reset.gnt0", 8'(gnt0), 8'd0);
        checkOutput("reset.gnt1", 8'(gnt1), 8'd0);
        checkOutput("reset.mem_we", 8'(mem_we), 8'd0);
        checkOutput("reset.rvalid", 8'({rvalid0, rvalid1}), 8'd0);
        checkOutput("reset.estouro", 8'(estouro), 8'd0);
        resetDut();

        // Write then read on port 0; port 1 strobes while not owner must be ignored.
        vecs.push_back(mk(1, 0, 2'd0, 0));
        vecs.push_back(mk(1, 0, 2'd1, 0, 1, 1, 4'd3, 4'h5));
        vecs.push_back(mk(1, 0, 2'd1, 0, 1, 0, 4'd3, 4'h0, 1, 1, 4'd3, 4'hA));
        vecs.push_back(mk(1, 0, 2'd1, 0, 1, 0, 4'd3, 4'h0, 1, 1, 4'd3, 4'hA));
        vecs.push_back(mk(0, 0, 2'd1, 0, 1, 0, 4'd3, 4'h0));
        vecs.push_back(mk(0, 0, 2'd3, 0));
        vecs.push_back(mk(0, 0, 2'd0, 0));
        runTable("basic");

        // Contention from reset: port 0 first, handoff gap, then alternation.
        resetDut();
        vecs.push_back(mk(1, 1, 2'd0, 0));
        vecs.push_back(mk(1, 1, 2'd1, 0));
        vecs.push_back(mk(0, 1, 2'd1, 0));
        vecs.push_back(mk(0, 1, 2'd3, 0));
        vecs.push_back(mk(1, 1, 2'd2, 0, 0, 0, 4'd0, 4'd0, 1, 0, 4'd3, 4'd0));
        vecs.push_back(mk(1, 0, 2'd2, 0));
        vecs.push_back(mk(1, 1, 2'd3, 0));
        vecs.push_back(mk(0, 1, 2'd1, 0));
        vecs.push_back(mk(0, 0, 2'd3, 0));
        vecs.push_back(mk(0, 0, 2'd0, 0));
        runTable("rr");

        // Port 1 holds past the limit: 8 granted cycles, estouro, blocked until req1 drops.
        resetDut();
        vecs.push_back(mk(0, 1, 2'd0, 0));
        vecs.push_back(mk(0, 1, 2'd2, 0));
        vecs.push_back(mk(0, 1, 2'd2, 0));
        for (int k = 0; k < 6; k++) vecs.push_back(mk(1, 1, 2'd2, 0));
        vecs.push_back(mk(1, 1, 2'd3, 1));
        vecs.push_back(mk(1, 1, 2'd1, 0));
        vecs.push_back(mk(0, 1, 2'd1, 0));
        vecs.push_back(mk(0, 1, 2'd3, 0));
        vecs.push_back(mk(0, 1, 2'd0, 0));
        vecs.push_back(mk(0, 0, 2'd0, 0));
        vecs.push_back(mk(0, 1, 2'd0, 0));
        vecs.push_back(mk(0, 0, 2'd2, 0));
        vecs.push_back(mk(0, 0, 2'd3, 0));
        vecs.push_back(mk(0, 0, 2'd0, 0));
        runTable("timeout");

        // Release on the limit cycle is a plain release: no estouro and port 0 not blocked.
        resetDut();
        vecs.push_back(mk(1, 0, 2'd0, 0));
        for (int k = 0; k < 7; k++) vecs.push_back(mk(1, 0, 2'd1, 0));
        vecs.push_back(mk(0, 0, 2'd1, 0));
        vecs.push_back(mk(1, 0, 2'd3, 0));
        vecs.push_back(mk(0, 0, 2'd1, 0));
        vecs.push_back(mk(0, 0, 2'd3, 0));
        vecs.push_back(mk(0, 0, 2'd0, 0));
        runTable("release_at_limit");

        // Reset asserted mid-cycle while port 1 owns the RAM with a read pending.
        resetDut();
        @(negedge clock);
        applyStimulus(mk(0, 1, 2'd0, 0));
        @(negedge clock);
        applyStimulus(mk(0, 1, 2'd2, 0, 0, 0, 4'd0, 4'd0, 1, 0, 4'd3, 4'd0));
        #1;
        checkOutput("async.gnt1_before", 8'(gnt1), 8'd1);
        @(negedge clock);
        applyStimulus(mk(0, 1, 2'd2, 0, 0, 0, 4'd0, 4'd0, 1, 1, 4'd5, 4'd9));
        #1;
        checkOutput("async.rvalid1_before", 8'(rvalid1), 8'd1);
        checkOutput("async.mem_we_before", 8'(mem_we), 8'd1);
        #1 reset = 1'b1;
        #1;
        checkOutput("async.gnt1", 8'(gnt1), 8'd0);
        checkOutput("async.mem_we", 8'(mem_we), 8'd0);
        checkOutput("async.rvalid1", 8'(rvalid1), 8'd0);
        checkOutput("async.db_estado", 8'(db_estado), 8'd0);
        checkOutput("async.mem_addr", 8'(mem_addr), 8'd0);
        @(negedge clock);
        reset = 1'b0;
        applyStimulus(mk(0, 0, 2'd0, 0));
        @(negedge clock);
        #1;
        checkOutput("async.after_db_estado", 8'(db_estado), 8'd0);
        checkOutput("async.after_rvalid1", 8'(rvalid1), 8'd0);
        checkOutput("async.ram5_untouched", 8'(ram[5]), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
